stream_deparser_emitter: RTL
============================

// Module: stream_deparser_emitter
// PURPOSE
//  Transmit-side counterpart of the stream parser front end: re-serialises packets into the 134b stream format.
//  Pops one header/meta word per packet, then reads buffered packet beats from the packet FIFO.
//  Overwrites the first HEAD_BEATS payload fields with the (possibly modified) header and emits o_data/o_data_valid.
//  Sits after the deparser, between the pkt/meta FIFOs and the egress port. Meta may mark a packet for drop.
// PARAMETERS
//  HEAD_BEATS  4   beats of header carried in meta; header width HEAD_W = HEAD_BEATS*128
//  CNT_W       32  width of statistics counters
// PORTS
//  i_clk          in   1          clock
//  i_rst          in   1          asynchronous reset, active-high
//  i_pkt_empty    in   1          pkt FIFO empty (first-word-fall-through)
//  i_pkt          in   134        pkt FIFO head beat: [133:132] tag, [131:128] valid, [127:0] data
//  o_pkt_rden     out  1          pop pkt FIFO (combinational)
//  i_meta_empty   in   1          meta FIFO empty (first-word-fall-through)
//  i_meta         in   HEAD_W+1   [HEAD_W] drop flag, [HEAD_W-1:0] header, first beat in MSBs
//  o_meta_rden    out  1          pop meta FIFO (combinational)
//  o_data_valid   out  1          output beat valid (registered)
//  o_data         out  134        output beat, 134b format (registered)
//  o_pkt_cnt      out  CNT_W      packets emitted
//  o_drop_cnt     out  CNT_W      packets dropped on meta request
//  o_err_cnt      out  CNT_W      packets whose first beat lacked the head tag
// BEHAVIOUR
//  Reset: state IDLE; o_data_valid=0; o_data=0; all counters 0; header/drop latches 0; beat index 0.
//  Reset is honoured mid-packet: the partial packet is abandoned with no tail emitted; FIFOs are not flushed here.
//  Tags: 2'b01 head, 2'b10 tail, 2'b11 head+tail (single beat), 2'b00 body. Valid nibble passes through unmodified.
//  FSM IDLE: when !i_meta_empty && !i_pkt_empty, assert o_meta_rden for one cycle and latch header and drop. -> SEND.
//  FSM SEND: each cycle with !i_pkt_empty, assert o_pkt_rden.
//   - First beat without the head bit (tag[0]==0): o_err_cnt+1, latch err, treat as DRAIN.
//   - Beat k < HEAD_BEATS: data[127:0] is replaced by header[HEAD_W-1-128*k -: 128]. Tag and valid are kept.
//   - Beats k >= HEAD_BEATS pass through unchanged. Beat index saturates at HEAD_BEATS.
//   - If drop or err is set: beats are popped but o_data_valid stays 0.
//   - Beat with the tail bit (tag[1]): -> IDLE, beat index cleared.
//     Exactly one of o_pkt_cnt, o_drop_cnt or o_err_cnt (already counted) is incremented.
//  i_pkt_empty during SEND: no pop, o_data_valid=0 that cycle (bubble). Output beats stay in order; no timeout.
//  Latency: a beat popped in cycle n appears on o_data in cycle n+1.
//  Minimum one idle output cycle between packets (the meta pop cycle). Meta is never popped in SEND.
//  Packet shorter than HEAD_BEATS: only the beats present are overwritten; surplus header bytes are discarded.
//  Counters wrap modulo 2^CNT_W. o_data holds its last value when o_data_valid=0.
//  Meta available while the pkt FIFO is empty: stay in IDLE, no pop.
// STRUCTURE
//  Shared package: tag constants (TAG_HEAD, TAG_TAIL, TAG_SINGLE, TAG_BODY).
//  Also in the package: 134b field slice localparams and the 128b beat width.
//  FSM state enum {IDLE, SEND} is local.
//  One natural sub-module: stream_hdr_merge.
//   - Combinational: beat index + header + beat -> merged beat.
//   - Kept separate so it can be unit-tested against the parser's header extraction.
// TESTING
//  1. 6-beat pkt (01,00x4,10) with header 512'hA..A0..0F, drop=0.
//     -> beats 0-3 data = header slices MSB-first; beats 4-5 unchanged; o_pkt_cnt=1.
//  2. Single beat tag 11, valid 4'b0011 -> one output beat with valid=4'b0011 and data = header[511:384]; FSM back in IDLE.
//  3. drop=1 on a 3-beat pkt -> 3 pops, o_data_valid never 1, o_drop_cnt=1, o_pkt_cnt unchanged.
//  4. First beat tag 00, then a tail 2 beats later -> 3 pops, no output, o_err_cnt=1.
//     Next valid pkt is emitted normally.
//  5. i_pkt_empty toggled every other cycle mid-packet -> output has bubbles, beat order intact, header overwrite still on beats 0-3.
//  6. i_rst pulsed during beat 2 of 5 -> o_data_valid=0 and counters 0 within the reset cycle.
//     Next meta pop starts a fresh packet at beat index 0.

Source files
------------

// File: rtl/stream_deparser_emitter_pkg.sv
// Shared definitions for the 134b stream format: tag codes, field slices, beat widths.
package stream_deparser_emitter_pkg;

    localparam int BEAT_W  = 134;
    localparam int DATA_W  = 128;
    localparam int TAG_MSB = 133;
    localparam int TAG_LSB = 132;
    localparam int VLD_MSB = 131;
    localparam int VLD_LSB = 128;

    localparam logic [1:0] TAG_BODY   = 2'b00;
    localparam logic [1:0] TAG_HEAD   = 2'b01;
    localparam logic [1:0] TAG_TAIL   = 2'b10;
    localparam logic [1:0] TAG_SINGLE = 2'b11;

    // Head bit is set for both head and single-beat tags.
    function automatic logic tag_has_head(input logic [1:0] tag);
        return tag[0];
    endfunction

    // Tail bit is set for both tail and single-beat tags.
    function automatic logic tag_has_tail(input logic [1:0] tag);
        return tag[1];
    endfunction

endpackage

// File: rtl/stream_deparser_emitter_hdr_merge.sv
// Combinational header overlay: beat k < HEAD_BEATS gets header slice k (MSB-first) in its data field.
module stream_hdr_merge
    import stream_deparser_emitter_pkg::*;
#(
    parameter int  HEAD_BEATS = 4,
    localparam int HEAD_W     = HEAD_BEATS * DATA_W,
    localparam int IDX_W      = $clog2(HEAD_BEATS + 1)
) (
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [HEAD_W-1:0] i_hdr,
    input  logic [BEAT_W-1:0] i_beat,
    output logic [BEAT_W-1:0] o_beat
);

    localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(HEAD_BEATS);

    logic [DATA_W-1:0] slice_s;

    // One-hot select of the header slice addressed by the beat index.
    always_comb begin
        slice_s = {DATA_W{1'b0}};
        for (int k = 0; k < HEAD_BEATS; k++) begin
            slice_s = slice_s | ({DATA_W{i_idx == IDX_W'(k)}} & i_hdr[HEAD_W-1-DATA_W*k -: DATA_W]);
        end
    end

    // Tag and valid pass through; data is replaced only inside the header window.
    always_comb begin
        o_beat = {i_beat[TAG_MSB:VLD_LSB], (i_idx < IDX_LIMIT) ? slice_s : i_beat[DATA_W-1:0]};
    end

endmodule

// File: rtl/stream_deparser_emitter.sv
// Egress emitter: pops one meta word per packet, overlays the header onto the first
// beats of the buffered packet and re-emits the 134b stream; handles drop and bad-head.
module stream_deparser_emitter
    import stream_deparser_emitter_pkg::*;
#(
    parameter int  HEAD_BEATS = 4,
    parameter int  CNT_W      = 32,
    localparam int HEAD_W     = HEAD_BEATS * DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pkt_empty,
    input  logic [BEAT_W-1:0] i_pkt,
    output logic              o_pkt_rden,
    input  logic              i_meta_empty,
    input  logic [HEAD_W:0]   i_meta,
    output logic              o_meta_rden,
    output logic              o_data_valid,
    output logic [BEAT_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_pkt_cnt,
    output logic [CNT_W-1:0]  o_drop_cnt,
    output logic [CNT_W-1:0]  o_err_cnt
);

    localparam int               IDX_W   = $clog2(HEAD_BEATS + 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(HEAD_BEATS);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [HEAD_W-1:0] hdr_q, hdr_d;
    logic              drop_q, drop_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              data_valid_q, data_valid_d;
    logic [BEAT_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic              pkt_rden_s;
    logic              meta_rden_s;
    logic              err_now_s;
    logic [1:0]        tag_s;
    logic [BEAT_W-1:0] merged_s;

    assign tag_s     = i_pkt[TAG_MSB:TAG_LSB];
    // A first beat lacking the head bit marks the whole packet as malformed.
    assign err_now_s = (state_q == SEND) && !i_pkt_empty && (idx_q == {IDX_W{1'b0}}) && !tag_has_head(tag_s);

    stream_hdr_merge #(.HEAD_BEATS(HEAD_BEATS)) u_merge (
        .i_idx  (idx_q),
        .i_hdr  (hdr_q),
        .i_beat (i_pkt),
        .o_beat (merged_s)
    );

    // Next-state logic: meta pop in IDLE, beat pop / overlay / accounting in SEND.
    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        drop_d       = drop_q;
        err_d        = err_q;
        idx_d        = idx_q;
        data_valid_d = 1'b0;
        data_d       = data_q;
        pkt_cnt_d    = pkt_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        err_cnt_d    = err_cnt_q;
        pkt_rden_s   = 1'b0;
        meta_rden_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_meta_empty && !i_pkt_empty) begin
                    meta_rden_s = 1'b1;
                    hdr_d       = i_meta[HEAD_W-1:0];
                    drop_d      = i_meta[HEAD_W];
                    err_d       = 1'b0;
                    idx_d       = {IDX_W{1'b0}};
                    state_d     = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (!i_pkt_empty) begin
                    pkt_rden_s = 1'b1;
                    if (err_now_s) begin
                        err_d     = 1'b1;
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end else begin
                        err_d = err_q;
                    end
                    if (drop_q || err_q || err_now_s) begin
                        data_valid_d = 1'b0;
                    end else begin
                        data_valid_d = 1'b1;
                        data_d       = merged_s;
                    end
                    if (tag_has_tail(tag_s)) begin
                        state_d = IDLE;
                        idx_d   = {IDX_W{1'b0}};
                        if (err_q || err_now_s) begin
                            pkt_cnt_d = pkt_cnt_q;
                        end else if (drop_q) begin
                            drop_cnt_d = drop_cnt_q + CNT_W'(1);
                        end else begin
                            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                        end
                    end else if (idx_q < IDX_MAX) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        idx_d = idx_q;
                    end
                end else begin
                    data_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latches, registered outputs and counters; async reset abandons any packet in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            hdr_q        <= {HEAD_W{1'b0}};
            drop_q       <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= {IDX_W{1'b0}};
            data_valid_q <= 1'b0;
            data_q       <= {BEAT_W{1'b0}};
            pkt_cnt_q    <= {CNT_W{1'b0}};
            drop_cnt_q   <= {CNT_W{1'b0}};
            err_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            drop_q       <= drop_d;
            err_q        <= err_d;
            idx_q        <= idx_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign o_pkt_rden   = pkt_rden_s;
    assign o_meta_rden  = meta_rden_s;
    assign o_data_valid = data_valid_q;
    assign o_data       = data_q;
    assign o_pkt_cnt    = pkt_cnt_q;
    assign o_drop_cnt   = drop_cnt_q;
    assign o_err_cnt    = err_cnt_q;

endmodule
